// File: rtl/pixel_scan_ctrl.sv
// Dual-lane pixel scan sequencer: first beat 1 cycle after start, outputs frozen while rdy=0.
// Define SCAN_DUAL_ROW_EN to pair lanes vertically (row, row+1) instead of horizontally.
module pixel_scan_ctrl #(
  parameter int IDX_W = 11,
  parameter int CH_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] cfg_rows,
  input  logic [IDX_W-1:0] cfg_cols,
  input  logic [CH_W-1:0]  cfg_chans,
  input  logic             start,
  input  logic             abort,
  input  logic             rdy,
  output logic [IDX_W-1:0] row_idx1,
  output logic [IDX_W-1:0] col_idx1,
  output logic [IDX_W-1:0] row_idx2,
  output logic [IDX_W-1:0] col_idx2,
  output logic             lane2_vld,
  output logic [CH_W-1:0]  channel_num,
  output logic             data_start,
  output logic             data_end,
  output logic             data_vaild,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rows_q, cols_q, row_q, col_q;
  logic [CH_W-1:0]  chans_q, ch_q;
  logic [IDX_W-1:0] row_nxt, col_nxt;

  // One extra bit keeps index+1/index+2 exact even at the maximum frame size.
  logic [IDX_W:0] rows_x, cols_x, row_p1, col_p1;
  logic           cfg_ok, col_last, row_last, ch_last, lane2_ok, accept;

  assign rows_x = {1'b0, rows_q};
  assign cols_x = {1'b0, cols_q};
  assign row_p1 = {1'b0, row_q} + 1'b1;
  assign col_p1 = {1'b0, col_q} + 1'b1;

`ifdef SCAN_DUAL_ROW_EN
  logic [IDX_W:0] row_p2;
  assign row_p2   = {1'b0, row_q} + 2'd2;
  assign col_last = col_p1 >= cols_x;
  assign row_last = row_p2 >= rows_x;
  assign lane2_ok = row_p1 < rows_x;
  assign col_nxt  = col_p1[IDX_W-1:0];
  assign row_nxt  = row_p2[IDX_W-1:0];
`else
  logic [IDX_W:0] col_p2;
  assign col_p2   = {1'b0, col_q} + 2'd2;
  assign col_last = col_p2 >= cols_x;
  assign row_last = row_p1 >= rows_x;
  assign lane2_ok = col_p1 < cols_x;
  assign col_nxt  = col_p2[IDX_W-1:0];
  assign row_nxt  = row_p1[IDX_W-1:0];
`endif

  assign cfg_ok  = (cfg_rows != '0) && (cfg_cols != '0) && (cfg_chans != '0);
  assign ch_last = ch_q == (chans_q - 1'b1);
  // abort wins over a beat handed over in the same cycle
  assign accept  = (state_q == S_RUN) && rdy && !abort;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = cfg_ok ? S_RUN : S_DONE;
      S_RUN: begin
        if (abort) state_d = S_IDLE;
        else if (accept && col_last && row_last && ch_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      chans_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start && cfg_ok) begin
        rows_q  <= cfg_rows;
        cols_q  <= cfg_cols;
        chans_q <= cfg_chans;
        row_q   <= '0;
        col_q   <= '0;
        ch_q    <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          if (row_last) begin
            row_q <= '0;
            ch_q  <= ch_q + 1'b1;
          end else begin
            row_q <= row_nxt;
          end
        end else begin
          col_q <= col_nxt;
        end
      end
    end
  end

  always_comb begin
    row_idx1    = '0;
    col_idx1    = '0;
    row_idx2    = '0;
    col_idx2    = '0;
    lane2_vld   = 1'b0;
    channel_num = '0;
    data_start  = 1'b0;
    data_end    = 1'b0;
    data_vaild  = 1'b0;
    busy        = 1'b0;
    done        = state_q == S_DONE;
    if (state_q == S_RUN) begin
      data_vaild  = 1'b1;
      busy        = 1'b1;
      row_idx1    = row_q;
      col_idx1    = col_q;
      channel_num = ch_q;
      lane2_vld   = lane2_ok;
      data_start  = (row_q == '0) && (col_q == '0);
      data_end    = row_last && col_last;
      if (lane2_ok) begin
`ifdef SCAN_DUAL_ROW_EN
        row_idx2 = row_p1[IDX_W-1:0];
        col_idx2 = col_q;
`else
        row_idx2 = row_q;
        col_idx2 = col_p1[IDX_W-1:0];
`endif
      end
    end
  end

endmodule
